// File: rtl/pcs_link_pkg.sv
// Shared types and widths for the per-lane link bring-up sequencer.
package pcs_link_pkg;

  typedef enum logic [2:0] {
    DISABLED  = 3'd0,
    WAIT_PMA  = 3'd1,
    PCS_RST   = 3'd2,
    WAIT_LOCK = 3'd3,
    STABLE    = 3'd4,
    UP        = 3'd5,
    BACKOFF   = 3'd6
  } link_state_t;

  localparam int unsigned RETRY_CNT_W = 8;
  localparam int unsigned LOSS_CNT_W  = 16;

  // Largest of the four timing parameters; sizes the shared state timer.
  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: step on inc_i, hold once all ones.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pcs_link_ctrl.sv
// Per-lane 10GBASE-R bring-up sequencer: PMA wait, ordered PCS reset release,
// block-lock qualification, lock timeout with RX backoff, link-up reporting.
module pcs_link_ctrl
  import pcs_link_pkg::*;
#(
  parameter int unsigned PCS_RST_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT   = 65536,
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned BACKOFF_CYCLES = 256
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   enable_i,
  input  logic                   pll_locked_i,
  input  logic                   pma_tx_rdy_i,
  input  logic                   pma_rx_rdy_i,
  input  logic                   pma_sync_i,
  output logic                   pcs_tx_rst_o,
  output logic                   pcs_rx_rst_o,
  output logic                   tx_idle_force_o,
  output logic                   link_up_o,
  output logic [2:0]             state_o,
  output logic                   timeout_o,
  output logic [RETRY_CNT_W-1:0] retry_cnt_o,
  output logic [LOSS_CNT_W-1:0]  lock_loss_cnt_o
);

  localparam int unsigned MaxCycles =
      max4(PCS_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES, BACKOFF_CYCLES);
  localparam int unsigned TimerW = $clog2(MaxCycles) + 1;

  localparam logic [TimerW-1:0] PcsRstLast  = TimerW'(PCS_RST_CYCLES - 1);
  localparam logic [TimerW-1:0] LockLast    = TimerW'(LOCK_TIMEOUT - 1);
  localparam logic [TimerW-1:0] StableLast  = TimerW'(STABLE_CYCLES - 1);
  localparam logic [TimerW-1:0] BackoffLast = TimerW'(BACKOFF_CYCLES - 1);

  link_state_t       state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              tx_rst_q, tx_rst_d;
  logic              rx_rst_q, rx_rst_d;
  logic              idle_q, idle_d;
  logic              link_q, link_d;
  logic              timeout_q, timeout_d;
  logic              pma_ok;
  logic              loss_inc;

  assign pma_ok = pll_locked_i & pma_tx_rdy_i & pma_rx_rdy_i;

  // Next-state selection in priority order: enable, PMA health, per-state rules.
  always_comb begin
    state_d = state_q;
    if (!enable_i) begin
      state_d = DISABLED;
    end else if (!pma_ok && (state_q inside {PCS_RST, WAIT_LOCK, STABLE, UP, BACKOFF})) begin
      state_d = WAIT_PMA;
    end else begin
      case (state_q)
        DISABLED:  state_d = WAIT_PMA;
        WAIT_PMA:  if (pma_ok) state_d = PCS_RST;
        PCS_RST:   if (timer_q == PcsRstLast) state_d = WAIT_LOCK;
        WAIT_LOCK: begin
          // Lock arriving in the expiry cycle takes precedence over the timeout.
          if (pma_sync_i)                 state_d = STABLE;
          else if (timer_q == LockLast)   state_d = BACKOFF;
        end
        STABLE: begin
          if (!pma_sync_i)                state_d = WAIT_LOCK;
          else if (timer_q == StableLast) state_d = UP;
        end
        UP:        if (!pma_sync_i) state_d = WAIT_LOCK;
        BACKOFF:   if (timer_q == BackoffLast) state_d = WAIT_LOCK;
        default:   state_d = DISABLED;
      endcase
    end
  end

  // Timer restarts on every state change; output values decoded from next state
  // so registered outputs move in the same cycle as the state register.
  always_comb begin
    timer_d   = (state_d != state_q) ? '0 : timer_q + 1'b1;
    tx_rst_d  = state_d inside {DISABLED, WAIT_PMA, PCS_RST};
    rx_rst_d  = tx_rst_d | (state_d == BACKOFF);
    link_d    = (state_d == UP);
    idle_d    = ~link_d;
    timeout_d = (state_d == BACKOFF) && (state_q != BACKOFF);
  end

  // With enable high, any exit from UP is a sync or PMA loss.
  assign loss_inc = (state_q == UP) && (state_d != UP) && enable_i;

  // State, timer and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= DISABLED;
      timer_q   <= '0;
      tx_rst_q  <= 1'b1;
      rx_rst_q  <= 1'b1;
      idle_q    <= 1'b1;
      link_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      tx_rst_q  <= tx_rst_d;
      rx_rst_q  <= rx_rst_d;
      idle_q    <= idle_d;
      link_q    <= link_d;
      timeout_q <= timeout_d;
    end
  end

  sat_counter #(
    .W(RETRY_CNT_W)
  ) u_retry_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (timeout_d),
    .cnt_o (retry_cnt_o)
  );

  sat_counter #(
    .W(LOSS_CNT_W)
  ) u_loss_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (loss_inc),
    .cnt_o (lock_loss_cnt_o)
  );

  assign state_o         = state_q;
  assign pcs_tx_rst_o    = tx_rst_q;
  assign pcs_rx_rst_o    = rx_rst_q;
  assign tx_idle_force_o = idle_q;
  assign link_up_o       = link_q;
  assign timeout_o       = timeout_q;

endmodule

// File: tb/tb_pcs_link_ctrl.sv
// Directed bench for pcs_link_ctrl with short timing parameters.
module tb_pcs_link_ctrl;

  localparam int unsigned PcsRst  = 8;
  localparam int unsigned LockTo  = 100;
  localparam int unsigned Stable  = 20;
  localparam int unsigned Backoff = 16;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        pll_locked;
  logic        pma_tx_rdy;
  logic        pma_rx_rdy;
  logic        pma_sync;
  logic        pcs_tx_rst;
  logic        pcs_rx_rst;
  logic        tx_idle_force;
  logic        link_up;
  logic [2:0]  state;
  logic        timeout;
  logic [7:0]  retry_cnt;
  logic [15:0] lock_loss_cnt;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int to_cnt   = 0;

  pcs_link_ctrl #(
    .PCS_RST_CYCLES (PcsRst),
    .LOCK_TIMEOUT   (LockTo),
    .STABLE_CYCLES  (Stable),
    .BACKOFF_CYCLES (Backoff)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .enable_i        (enable),
    .pll_locked_i    (pll_locked),
    .pma_tx_rdy_i    (pma_tx_rdy),
    .pma_rx_rdy_i    (pma_rx_rdy),
    .pma_sync_i      (pma_sync),
    .pcs_tx_rst_o    (pcs_tx_rst),
    .pcs_rx_rst_o    (pcs_rx_rst),
    .tx_idle_force_o (tx_idle_force),
    .link_up_o       (link_up),
    .state_o         (state),
    .timeout_o       (timeout),
    .retry_cnt_o     (retry_cnt),
    .lock_loss_cnt_o (lock_loss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s @cycle %0d: observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  // One clock; sampling and driving happen 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (timeout === 1'b1) to_cnt++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  // Leaves the bench in cycle 0: the first cycle with rst low.
  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    cyc    = 0;
    to_cnt = 0;
  endtask

  task automatic pma_all(input logic v);
    pll_locked = v;
    pma_tx_rdy = v;
    pma_rx_rdy = v;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".state"},   16'(state), 16'd0);
    chk({tag, ".tx_rst"},  16'(pcs_tx_rst), 16'd1);
    chk({tag, ".rx_rst"},  16'(pcs_rx_rst), 16'd1);
    chk({tag, ".idle"},    16'(tx_idle_force), 16'd1);
    chk({tag, ".link"},    16'(link_up), 16'd0);
    chk({tag, ".timeout"}, 16'(timeout), 16'd0);
    chk({tag, ".retry"},   16'(retry_cnt), 16'd0);
    chk({tag, ".loss"},    lock_loss_cnt, 16'd0);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; pma_sync = 1'b0;
    pma_all(1'b0);

    // Clean bring-up.
    do_reset();
    enable = 1'b1; pma_all(1'b1); pma_sync = 1'b1;
    chk_reset_vals("rst0");
    run_to(1);  chk("up.wait_pma", 16'(state), 16'd1);
    run_to(2);  chk("up.pcs_rst_first", 16'(state), 16'd2);
    run_to(9);  chk("up.pcs_rst_last", 16'(state), 16'd2);
                chk("up.tx_rst_held", 16'(pcs_tx_rst), 16'd1);
    run_to(10); chk("up.wait_lock", 16'(state), 16'd3);
                chk("up.tx_rst_rel", 16'(pcs_tx_rst), 16'd0);
                chk("up.rx_rst_rel", 16'(pcs_rx_rst), 16'd0);
    run_to(11); chk("up.stable", 16'(state), 16'd4);
    run_to(30); chk("up.stable_last", 16'(state), 16'd4);
                chk("up.idle_in_stable", 16'(tx_idle_force), 16'd1);
    run_to(31); chk("up.up", 16'(state), 16'd5);
                chk("up.link_up", 16'(link_up), 16'd1);
                chk("up.idle_off", 16'(tx_idle_force), 16'd0);

    // Lock timeout and backoff.
    do_reset();
    enable = 1'b1; pma_all(1'b1); pma_sync = 1'b0;
    run_to(109); chk("to.before", 16'(state), 16'd3);
                 chk("to.no_pulse", 16'(timeout), 16'd0);
    run_to(110); chk("to.backoff", 16'(state), 16'd6);
                 chk("to.pulse", 16'(timeout), 16'd1);
                 chk("to.retry1", 16'(retry_cnt), 16'd1);
                 chk("to.rx_rst", 16'(pcs_rx_rst), 16'd1);
                 chk("to.tx_rst", 16'(pcs_tx_rst), 16'd0);
    run_to(111); chk("to.pulse_off", 16'(timeout), 16'd0);
    run_to(125); chk("to.backoff_last", 16'(state), 16'd6);
                 chk("to.rx_rst_last", 16'(pcs_rx_rst), 16'd1);
    run_to(126); chk("to.relock", 16'(state), 16'd3);
                 chk("to.rx_rst_rel", 16'(pcs_rx_rst), 16'd0);
                 chk("to.pulses", 16'(to_cnt), 16'd1);

    // Lock arriving in the expiry cycle beats the timeout.
    do_reset();
    enable = 1'b1; pma_all(1'b1); pma_sync = 1'b0;
    run_to(109); pma_sync = 1'b1;
    run_to(110); chk("edge.stable", 16'(state), 16'd4);
                 chk("edge.no_pulse", 16'(timeout), 16'd0);
                 chk("edge.retry0", 16'(retry_cnt), 16'd0);

    // One-cycle sync glitch in STABLE.
    do_reset();
    enable = 1'b1; pma_all(1'b1); pma_sync = 1'b1;
    run_to(20); pma_sync = 1'b0;
    run_to(21); chk("gl.wait_lock", 16'(state), 16'd3);
                pma_sync = 1'b1;
    run_to(22); chk("gl.stable", 16'(state), 16'd4);
    run_to(41); chk("gl.not_up_yet", 16'(state), 16'd4);
    run_to(42); chk("gl.up", 16'(state), 16'd5);
                chk("gl.loss0", lock_loss_cnt, 16'd0);

    // Lock loss in UP, then PMA drop, then disable.
    do_reset();
    enable = 1'b1; pma_all(1'b1); pma_sync = 1'b1;
    run_to(50); pma_sync = 1'b0;
    run_to(51); chk("ll.wait_lock", 16'(state), 16'd3);
                chk("ll.link_down", 16'(link_up), 16'd0);
                chk("ll.loss1", lock_loss_cnt, 16'd1);
                pma_sync = 1'b1;
    run_to(71); chk("ll.stable_last", 16'(state), 16'd4);
    run_to(72); chk("ll.up_again", 16'(state), 16'd5);
    run_to(80); pma_rx_rdy = 1'b0; pma_sync = 1'b0;
    run_to(81); chk("pd.wait_pma", 16'(state), 16'd1);
                chk("pd.tx_rst", 16'(pcs_tx_rst), 16'd1);
                chk("pd.rx_rst", 16'(pcs_rx_rst), 16'd1);
                chk("pd.loss2", lock_loss_cnt, 16'd2);
                pma_rx_rdy = 1'b1; pma_sync = 1'b1; enable = 1'b0;
    run_to(82); chk("pd.disabled", 16'(state), 16'd0);
                chk("pd.loss_kept", lock_loss_cnt, 16'd2);
                enable = 1'b1;
    run_to(83);  chk("pd.reenable", 16'(state), 16'd1);
    run_to(113); chk("pd.up3", 16'(state), 16'd5);
    run_to(120); enable = 1'b0;
    run_to(121); chk("dis.disabled", 16'(state), 16'd0);
                 chk("dis.loss_no_inc", lock_loss_cnt, 16'd2);
                 chk("dis.retry0", 16'(retry_cnt), 16'd0);

    // Retry counter saturation, then reset from BACKOFF.
    do_reset();
    enable = 1'b1; pma_all(1'b1); pma_sync = 1'b0;
    run_to(29573); chk("sat.254", 16'(retry_cnt), 16'd254);
    run_to(29574); chk("sat.255", 16'(retry_cnt), 16'd255);
                   chk("sat.pulse255", 16'(timeout), 16'd1);
    run_to(34794); chk("sat.hold", 16'(retry_cnt), 16'd255);
                   chk("sat.backoff300", 16'(state), 16'd6);
                   chk("sat.pulses", 16'(to_cnt), 16'd300);
    run_to(34795); chk("sat.backoff2", 16'(state), 16'd6);
                   rst = 1'b1;
    run_to(34796); chk_reset_vals("rst1");
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/pcs_link_ctrl.md
Name: pcs_link_ctrl

Overview:
Per-lane 10GBASE-R link bring-up sequencer. It waits for the transceiver PLL and PMA to be ready, then releases the PCS resets in order and qualifies RX block lock. While the link is down it forces the TX PCS to send idles, and it retries lock acquisition with a timeout and backoff. One instance per transceiver lane sits between the PMA wrapper status outputs and the pcs_rx_32b/pcs_tx_32b reset and idle-force inputs.

Parameters:
PCS_RST_CYCLES, 16, cycles both PCS resets are held after the PMA becomes ready (>=2)
LOCK_TIMEOUT, 65536, cycles allowed in WAIT_LOCK before a retry (>=2)
STABLE_CYCLES, 1024, consecutive pma_sync cycles required before link_up (>=1)
BACKOFF_CYCLES, 256, cycles pcs_rx_rst is held after a lock timeout (>=1)

Ports:
clk  in  1  lane clock; every input is already synchronous to clk (upstream synchronizers are the integrator's responsibility)
rst  in  1  synchronous, active-high reset
enable  in  1  software lane enable; level
pll_locked  in  1  TX fPLL locked
pma_tx_rdy  in  1  PMA TX ready
pma_rx_rdy  in  1  PMA RX ready
pma_sync  in  1  block lock from pcs_rx_32b
pcs_tx_rst  out  1  reset to pcs_tx_32b
pcs_rx_rst  out  1  reset to pcs_rx_32b
tx_idle_force  out  1  forces the XGMII idle pattern into pcs_tx_32b
link_up  out  1  link qualified
state  out  3  current state encoding (link_state_t)
timeout  out  1  one-cycle pulse on each lock timeout
retry_cnt  out  8  lock timeouts since reset; saturates at 255
lock_loss_cnt  out  16  exits from UP since reset; saturates at 65535

Behaviour:
- Moore machine. All outputs are registered. Output changes occur in the same cycle the state register changes.
- Reset values: state=DISABLED, pcs_tx_rst=1, pcs_rx_rst=1, tx_idle_force=1, link_up=0, timeout=0, retry_cnt=0, lock_loss_cnt=0, timer=0.
- Transition priority, highest first:
  1. rst
  2. enable=0 forces DISABLED next cycle from any state
  3. pma_ok=0, where pma_ok = pll_locked & pma_tx_rdy & pma_rx_rdy, forces WAIT_PMA from PCS_RST, WAIT_LOCK, STABLE, UP or BACKOFF
  4. state-specific transitions below
- Shared timer: cleared on every state change, increments each cycle otherwise. Width is $clog2 of the largest parameter, plus 1.
- DISABLED (0): both resets=1, idle_force=1. enable=1 -> WAIT_PMA.
- WAIT_PMA (1): both resets=1. pma_ok=1 -> PCS_RST.
- PCS_RST (2): both resets=1. When timer = PCS_RST_CYCLES-1 -> WAIT_LOCK.
- WAIT_LOCK (3): pcs_tx_rst=0, pcs_rx_rst=0, idle_force=1.
  - pma_sync=1 -> STABLE.
  - Otherwise, when timer = LOCK_TIMEOUT-1 -> BACKOFF.
  - If pma_sync=1 arrives in the expiry cycle, STABLE wins and no timeout occurs.
- STABLE (4): resets=0, idle_force=1.
  - pma_sync=0 -> WAIT_LOCK, with the timer restarted.
  - When timer = STABLE_CYCLES-1 with pma_sync=1 -> UP.
- UP (5): resets=0, idle_force=0, link_up=1.
  - pma_sync=0 -> WAIT_LOCK.
  - lock_loss_cnt increments on any exit from UP caused by pma_sync=0 or pma_ok=0. It does not increment when the exit is caused by enable=0 or rst.
- BACKOFF (6): pcs_tx_rst=0, pcs_rx_rst=1, idle_force=1.
  - timeout=1 for the first BACKOFF cycle only; retry_cnt increments on entry.
  - When timer = BACKOFF_CYCLES-1 -> WAIT_LOCK.
- Encoding 7 is unused. If state=7, the next state is DISABLED.
- link_up is 1 only in UP. tx_idle_force = !link_up.
- Counters saturate and never wrap. They are cleared only by rst; enable=0 does not clear them.
- enable toggling mid-sequence restarts from DISABLED. No state is retained except the two counters.

Decomposition:
- Package pcs_link_pkg contains:
  - typedef enum logic [2:0] link_state_t with DISABLED..BACKOFF encoded 0..6
  - localparams RETRY_CNT_W=8 and LOSS_CNT_W=16
- One sub-module, sat_counter (parameter W; ports clk, rst, inc, cnt), instantiated twice, for retry_cnt and lock_loss_cnt.

Test Plan:
Parameters for all scenarios: PCS_RST_CYCLES=8, LOCK_TIMEOUT=100, STABLE_CYCLES=20, BACKOFF_CYCLES=16. Cycle 0 is the first cycle after rst deasserts.
- Clean bring-up: pma_ok=1, pma_sync=1, enable rises at cycle 0 -> WAIT_PMA@1, PCS_RST@2..9, WAIT_LOCK@10 (pcs_tx_rst=0), STABLE@11..30, UP@31 (link_up=1, tx_idle_force=0).
- Lock timeout: as the clean bring-up but pma_sync=0 -> BACKOFF@110 with timeout=1 for that cycle only and retry_cnt=1; pcs_rx_rst=1 @110..125; WAIT_LOCK@126.
- Unstable lock: pma_sync drops for 1 cycle at cycle 20, while in STABLE -> WAIT_LOCK@21, STABLE@22, UP@42; lock_loss_cnt stays 0.
- Lock loss in UP: pma_sync=0 at cycle 50 -> WAIT_LOCK@51, link_up=0@51, lock_loss_cnt=1; pma_sync=1 again -> UP after STABLE_CYCLES.
- PMA drop and disable: in UP, pma_rx_rdy=0 together with pma_sync=0 -> WAIT_PMA next cycle, both resets=1, lock_loss_cnt+1. Then enable=0 -> DISABLED; counters retained.
- Saturation and reset: force 300 timeouts -> retry_cnt=255 and holds. Assert rst in BACKOFF -> all outputs return to their reset values the next cycle.
